tx_scheduler: RTL
=================

# tx_scheduler

Arbitrates the single serial transmit engine of a router port among three packet sources: ACK/NACK responses, core data packets and token forwarding. It builds the 55-bit packet word, launches it with a one-cycle start pulse, and tracks the engine's ready handshake until the frame is complete. It sits between the core/RX control logic and the TX serializer. It also enforces the token rule, so data is sent only while the port holds the token.

## Interface
- `BUSY_TIMEOUT`, default 8: maximum cycles to wait for `ready` to fall after `start`.
- `MAX_DATA_BURST`, default 4: consecutive data grants allowed while a token request waits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rsp_req`  in  1  response pending; level, held until granted.
- `rsp_nack`  in  1  response type: 0 = ACK (type 000), 1 = NACK (type 011).
- `rsp_gnt`  out  1  one-cycle pulse when the response is launched.
- `dat_req`  in  1  data packet pending; level.
- `dat_kind`  in  1  data type: 0 = DATA-C (010), 1 = DATA-3 (001).
- `dat_payload`  in  52  packet bits [51:0]: 2-bit field plus 5×10-bit words.
- `dat_gnt`  out  1  one-cycle pulse when data is launched.
- `tok_req`  in  1  token forward pending; level.
- `tok_gnt`  out  1  one-cycle pulse when the token is launched.
- `token_held`  in  1  port owns the token; data is eligible only while this is 1.
- `TX_Data`  out  55  packet word to the serializer.
- `start`  out  1  one-cycle launch pulse to the serializer.
- `ready`  in  1  serializer idle (1) or shifting (0).
- `busy`  out  1  scheduler not in IDLE.
- `sent_done`  out  1  one-cycle pulse when a frame completes.
- `sent_type`  out  3  type field of the last completed frame.
- `err_timeout`  out  1  one-cycle pulse when `ready` never fell.

## Operation
- Packet format:
  - `TX_Data[54:52]` is the type field.
  - For ACK/NACK/TOKEN, bits [51:0] are 0.
  - For data, bits [51:0] are `dat_payload`.
  - TOKEN type is 111.
- Eligibility:
  - `rsp_req`.
  - `dat_req & token_held`.
  - `tok_req`.
- Priority: response > data > token.
- Anti-starvation:
  - `burst_cnt` counts data grants made while `tok_req` is high.
  - When `burst_cnt == MAX_DATA_BURST`, token is ranked above data (response still first).
  - `burst_cnt` clears on any token grant, or whenever `tok_req` is 0.
- States:
  - IDLE: if `ready == 1` and any eligible request, latch winner into `TX_Data`/`cur_type` → LAUNCH; else stay.
  - LAUNCH: `start = 1` and the matching `*_gnt = 1` for exactly this cycle → WAIT_BUSY; clear timeout counter.
  - WAIT_BUSY:
    - `ready == 0` → WAIT_DONE.
    - Counter reaches `BUSY_TIMEOUT` → pulse `err_timeout`, → IDLE (no `sent_done`).
  - WAIT_DONE: `ready == 1` → pulse `sent_done`, load `sent_type = cur_type`, → IDLE.
- `TX_Data` changes only on the IDLE→LAUNCH transition. It holds its last value otherwise.
- Requests dropped after grant have no effect. Requests raised during a frame wait for IDLE.
- `token_held` falling mid-frame does not abort a data frame already launched.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - `TX_Data`, `sent_type`, `burst_cnt` all 0.
  - `start`, all `*_gnt`, `busy`, `sent_done`, `err_timeout` all 0.
- Request-to-start latency: 2 cycles (request sampled in IDLE in cycle N, `start` high in N+1). Example: `rsp_req` first seen high at edge k → `start` and `rsp_gnt` high after edge k+1.
- `busy` is 1 from LAUNCH through the cycle `sent_done`/`err_timeout` pulses. It is 0 in IDLE.
- Back-to-back frames: the minimum gap from `sent_done` to the next `start` is 1 IDLE cycle.
- Simultaneous requests in one IDLE cycle resolve by priority. Losers stay pending with no grant.
- Timeout counts cycles in WAIT_BUSY, starting at 1 in the first WAIT_BUSY cycle.
- Reset asserted mid-frame returns to IDLE immediately with all outputs at reset values, and no `sent_done`.

## Structure
- Shared package `router_pkg`:
  - Type constants `PKT_TOKEN = 3'b111`, `PKT_ACK = 3'b000`, `PKT_NACK = 3'b011`, `PKT_DATAC = 3'b010`, `PKT_DATA3 = 3'b001`.
  - `PKT_W = 55`.
  - State encoding.
- One sub-module: `tx_prio_sel`, the combinational priority/anti-starvation selector producing a one-hot winner.
- The FSM, counters and registers stay in `tx_scheduler`.

## Test plan
- Reset then single `tok_req`, `ready` model falling 2 cycles after `start` and rising 60 cycles later → `TX_Data = 111` followed by 52 zeros, one `start` pulse, `tok_gnt` pulse, `sent_done` with `sent_type = 111`.
- `rsp_req`, `dat_req`, `tok_req` all raised in the same cycle, `token_held = 1` → grant order rsp (ACK 000), data, token. Each `start` is preceded by `sent_done`.
- `dat_req` with `dat_kind = 1`, payload = 1, `token_held = 0` for 20 cycles → no grant, `busy = 0`. Raise `token_held` → `TX_Data = 001` with bits [51:0] = 1, granted after 2 cycles.
- `dat_req` and `tok_req` held continuously, `token_held = 1` → exactly 4 `dat_gnt` pulses, then `tok_gnt`, then data resumes.
- Serializer model never drops `ready` → `err_timeout` pulses exactly 8 cycles after LAUNCH, no `sent_done`, next request is accepted.
- Assert `rst` low during WAIT_DONE → all outputs at reset values immediately. After release, a pending `rsp_req` with `rsp_nack = 1` launches type 011.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared packet types, widths and TX scheduler state encoding
package router_pkg;

    localparam int PKT_W = 55;

    localparam logic [2:0] PKT_TOKEN = 3'b111;
    localparam logic [2:0] PKT_ACK   = 3'b000;
    localparam logic [2:0] PKT_NACK  = 3'b011;
    localparam logic [2:0] PKT_DATAC = 3'b010;
    localparam logic [2:0] PKT_DATA3 = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_e;

    // One-hot winner of the source arbitration.
    typedef struct packed {
        logic tok;
        logic dat;
        logic rsp;
    } tx_win_t;

    function automatic logic [PKT_W-1:0] build_pkt(input logic [2:0] pkt_type,
                                                   input logic [PKT_W-4:0] body);
        return {pkt_type, body};
    endfunction

endpackage

// File: rtl/tx_prio_sel.sv
// rtl/tx_prio_sel.sv - combinational response/data/token priority selector with burst override
module tx_prio_sel
    import router_pkg::*;
(
    input  logic    rsp_req_i,
    input  logic    dat_req_i,
    input  logic    token_held_i,
    input  logic    tok_req_i,
    input  logic    burst_full_i,
    output tx_win_t win_o
);

    // A full data burst lifts a waiting token above data; responses always win.
    always_comb begin
        win_o = '0;
        if (rsp_req_i) begin
            win_o.rsp = 1'b1;
        end else if (tok_req_i && burst_full_i) begin
            win_o.tok = 1'b1;
        end else if (dat_req_i && token_held_i) begin
            win_o.dat = 1'b1;
        end else if (tok_req_i) begin
            win_o.tok = 1'b1;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - arbitrates response/data/token frames onto the serial TX engine
module tx_scheduler
    import router_pkg::*;
#(
    parameter int BUSY_TIMEOUT   = 8,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsp_req,
    input  logic             rsp_nack,
    output logic             rsp_gnt,
    input  logic             dat_req,
    input  logic             dat_kind,
    input  logic [51:0]      dat_payload,
    output logic             dat_gnt,
    input  logic             tok_req,
    output logic             tok_gnt,
    input  logic             token_held,
    output logic [PKT_W-1:0] TX_Data,
    output logic             start,
    input  logic             ready,
    output logic             busy,
    output logic             sent_done,
    output logic [2:0]       sent_type,
    output logic             err_timeout
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int BC_W = $clog2(MAX_DATA_BURST + 1);

    tx_state_e        state_q, state_d;
    logic [PKT_W-1:0] tx_data_q, tx_data_d;
    tx_win_t          win_q, win_d, win;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [BC_W-1:0]  burst_q, burst_d;
    logic [2:0]       sent_type_q, sent_type_d;
    logic             burst_full;
    logic [PKT_W-1:0] next_pkt;

    assign burst_full = (burst_q == BC_W'(MAX_DATA_BURST));

    tx_prio_sel u_prio (
        .rsp_req_i    (rsp_req),
        .dat_req_i    (dat_req),
        .token_held_i (token_held),
        .tok_req_i    (tok_req),
        .burst_full_i (burst_full),
        .win_o        (win)
    );

    always_comb begin
        next_pkt = build_pkt(PKT_TOKEN, '0);
        if (win.rsp) begin
            next_pkt = build_pkt(rsp_nack ? PKT_NACK : PKT_ACK, '0);
        end else if (win.dat) begin
            next_pkt = build_pkt(dat_kind ? PKT_DATA3 : PKT_DATAC, dat_payload);
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        win_d       = win_q;
        to_cnt_d    = to_cnt_q;
        burst_d     = burst_q;
        sent_type_d = sent_type_q;
        start       = 1'b0;
        rsp_gnt     = 1'b0;
        dat_gnt     = 1'b0;
        tok_gnt     = 1'b0;
        sent_done   = 1'b0;
        err_timeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ready && (win != '0)) begin
                    tx_data_d = next_pkt;
                    win_d     = win;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                start    = 1'b1;
                rsp_gnt  = win_q.rsp;
                dat_gnt  = win_q.dat;
                tok_gnt  = win_q.tok;
                to_cnt_d = TO_W'(1);
                state_d  = ST_WAIT_BUSY;
                if (win_q.tok) begin
                    burst_d = '0;
                end else if (win_q.dat && tok_req && !burst_full) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                // A late fall of ready on the last allowed cycle still counts as success.
                if (!ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT)) begin
                    err_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (ready) begin
                    sent_done   = 1'b1;
                    sent_type_d = tx_data_q[PKT_W-1 -: 3];
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!tok_req) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            win_q       <= '0;
            to_cnt_q    <= '0;
            burst_q     <= '0;
            sent_type_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            win_q       <= win_d;
            to_cnt_q    <= to_cnt_d;
            burst_q     <= burst_d;
            sent_type_q <= sent_type_d;
        end
    end

    assign TX_Data   = tx_data_q;
    assign sent_type = sent_type_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
